// File: rtl/vga_stream_tx_pkg.sv
// Shared definitions for the VGA pixel-stream transmitter.
//   - default 1024x768 timing set (overridable through module parameters)
//   - pixel word width ({r[3:0],g[3:0],b[3:0]})
//   - frame-lock state enum
//   - helper that maps an in-window flag to a polarity-aware sync level
package vga_pkg;

  localparam int PIX_W = 12;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  // HUNT: waiting for a start-of-frame word at raster origin.
  // SYNCED: stream is frame-aligned and its words are displayed.
  typedef enum logic {
    HUNT   = 1'b0,
    SYNCED = 1'b1
  } state_e;

  // Drive the active level inside the sync window, the idle level elsewhere.
  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_stream_tx_if.sv
// Upstream pixel stream: valid/ready handshake with a start-of-frame flag.
//   pix_data  : {r[3:0],g[3:0],b[3:0]}
//   pix_sof   : word is pixel (0,0) of a frame
//   pix_valid : source has a word
//   pix_ready : sink consumes the word this clock when pix_valid is also high
// master = pixel source, slave = transmitter.
interface vga_stream_tx_if
  import vga_pkg::*;
#(
  parameter int DATA_W = PIX_W
);
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output pix_data, pix_sof, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_sof, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/vga_stream_tx_timing.sv
// Raster position counters and combinational position decode.
// Ports:
//   clk      in  pixel clock
//   rst      in  asynchronous active-low reset
//   active_o out position is inside the visible area
//   hsync_o  out position is inside the horizontal sync window
//   vsync_o  out position is inside the vertical sync window
//   origin_o out position is visible pixel (0,0)
// The counters free-run; nothing upstream can stall them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Width-matched constants so every compare is HW/VW bits wide.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign active_o = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  assign hsync_o  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vsync_o  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign origin_o = active_o && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_stream_tx.sv
// Pixel-stream to VGA transmitter.
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous active-low reset
//   pix        slave stream (data/sof/valid in, ready out)
//   hs, vs     out  registered syncs (polarity from HS_POL/VS_POL)
//   de         out  registered active-video flag
//   r, g, b    out  registered colour, forced to 0 outside active video
//   underflow  out  1-clk pulse: active pixel with no valid word while synced
//   desync     out  1-clk pulse: start-of-frame misalignment detected
// All outputs carry the raster position of the previous clock; pix_ready is
// combinational from the current position. The raster never waits for the
// stream: missing or misaligned words turn into black pixels.
module vga_stream_tx
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic              clk,
  input  logic              rst,
  vga_stream_tx_if.slave    pix,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              underflow,
  output logic              desync
);

  logic active, hsync, vsync, origin;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .active_o (active),
    .hsync_o  (hsync),
    .vsync_o  (vsync),
    .origin_o (origin)
  );

  state_e           state_q, state_d;
  logic             ready;
  logic [PIX_W-1:0] rgb_d, rgb_q;
  logic             underflow_d, underflow_q;
  logic             desync_d, desync_q;
  logic             hs_q, vs_q, de_q;

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    rgb_d       = '0;
    underflow_d = 1'b0;
    desync_d    = 1'b0;
    unique case (state_q)
      HUNT: begin
        // Drain non-sof words at any time; an sof word waits for the origin.
        ready = pix.pix_valid && (!pix.pix_sof || origin);
        if (pix.pix_valid && pix.pix_sof && origin) begin
          rgb_d   = pix.pix_data;
          state_d = SYNCED;
        end
      end
      SYNCED: begin
        // An early sof is held so it can be accepted at the next origin.
        ready = active && !(pix.pix_valid && pix.pix_sof && !origin);
        if (active) begin
          // sof must coincide exactly with the origin; either mismatch
          // (early sof, or a non-sof word at origin) loses frame lock.
          if (pix.pix_valid && (pix.pix_sof != origin)) begin
            desync_d = 1'b1;
            state_d  = HUNT;
          end else if (pix.pix_valid) begin
            rgb_d = pix.pix_data;
          end else begin
            underflow_d = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign pix.pix_ready = ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
      desync_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_q        <= sync_level(hsync, HS_POL);
      vs_q        <= sync_level(vsync, VS_POL);
      de_q        <= active;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
      desync_q    <= desync_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign de        = de_q;
  assign r         = rgb_q[11:8];
  assign g         = rgb_q[7:4];
  assign b         = rgb_q[3:0];
  assign underflow = underflow_q;
  assign desync    = desync_q;

endmodule
